// File: rtl/slip_hdr_gen.sv
// Header source for the SLIP framer: emits a sequence number plus a snapshot of the
// running data-symbol counter every i_period accepted symbols, and null headers on request.
module slip_hdr_gen #(
    parameter int unsigned SYMBOL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PERIOD_WIDTH-1:0] i_period,
    input  logic                    i_dat_xfer,
    input  logic                    i_null_req,
    output logic [SYMBOL_WIDTH-1:0] o_hdr_data,
    output logic                    o_hdr_null,
    output logic                    o_hdr_last,
    output logic                    o_hdr_valid,
    input  logic                    i_hdr_ready,
    output logic                    o_overrun
);

    localparam int unsigned HDR_SYMBOLS = 1 + CNT_WIDTH / SYMBOL_WIDTH;
    localparam int unsigned IDX_WIDTH   = $clog2(HDR_SYMBOLS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HDR_SYMBOLS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StNull
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    tot_cnt_q, tot_cnt_d;
    logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
    logic                    pend_per_q, pend_per_d;
    logic                    pend_null_q, pend_null_d;
    logic [SYMBOL_WIDTH-1:0] seq_q, seq_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [CNT_WIDTH-1:0]    snap_q, snap_d;
    logic                    overrun_q, overrun_d;

    logic                    per_take;
    logic                    null_take;
    logic                    per_hit;
    logic [PERIOD_WIDTH:0]   phase_inc;
    logic [SYMBOL_WIDTH-1:0] hdr_data;

    // Period tracking; the compare is one bit wider so phase+1 cannot wrap.
    always_comb begin
        phase_inc = {1'b0, phase_q} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
        per_hit   = i_dat_xfer && (i_period != '0) && (phase_inc >= {1'b0, i_period});
        phase_d   = phase_q;
        if (i_period == '0) begin
            phase_d = '0;
        end else if (i_dat_xfer) begin
            phase_d = per_hit ? '0 : phase_inc[PERIOD_WIDTH-1:0];
        end
    end

    always_comb begin
        tot_cnt_d   = tot_cnt_q + CNT_WIDTH'(i_dat_xfer);
        pend_per_d  = per_hit | (pend_per_q & ~per_take);
        overrun_d   = overrun_q | (per_hit & pend_per_q & ~per_take);
        pend_null_d = i_null_req | (pend_null_q & ~null_take);
    end

    // Symbol 0 is the sequence number; the rest are snapshot bytes, LSB first.
    always_comb begin
        hdr_data = seq_q;
        for (int unsigned i = 0; i < HDR_SYMBOLS - 1; i++) begin
            if (idx_q == IDX_WIDTH'(i + 1)) begin
                hdr_data = snap_q[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        snap_d      = snap_q;
        per_take    = 1'b0;
        null_take   = 1'b0;
        o_hdr_valid = 1'b0;
        o_hdr_null  = 1'b0;
        o_hdr_last  = 1'b0;
        o_hdr_data  = '0;
        unique case (state_q)
            StIdle: begin
                if (pend_per_q) begin
                    snap_d   = tot_cnt_q;
                    idx_d    = '0;
                    per_take = 1'b1;
                    state_d  = StSend;
                end else if (pend_null_q) begin
                    null_take = 1'b1;
                    state_d   = StNull;
                end
            end
            StSend: begin
                o_hdr_valid = 1'b1;
                o_hdr_data  = hdr_data;
                o_hdr_last  = (idx_q == LAST_IDX);
                if (i_hdr_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        seq_d   = seq_q + 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StNull: begin
                o_hdr_valid = 1'b1;
                o_hdr_null  = 1'b1;
                if (i_hdr_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_overrun = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tot_cnt_q   <= '0;
            phase_q     <= '0;
            pend_per_q  <= 1'b0;
            pend_null_q <= 1'b0;
            seq_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tot_cnt_q   <= tot_cnt_d;
            phase_q     <= phase_d;
            pend_per_q  <= pend_per_d;
            pend_null_q <= pend_null_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_slip_hdr_gen.sv
// Directed bench for slip_hdr_gen: periodic headers, stalls, null items, priority,
// overrun and mid-header reset, all against hand-computed header bytes.
module tb_slip_hdr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_period;
    logic        i_dat_xfer;
    logic        i_null_req;
    logic [7:0]  o_hdr_data;
    logic        o_hdr_null;
    logic        o_hdr_last;
    logic        o_hdr_valid;
    logic        i_hdr_ready;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_data [8];
    logic       cap_last [8];
    logic       cap_null;
    logic       cap_to;
    int         cap_cnt;
    logic [7:0] exp_hdr [5];

    slip_hdr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .i_period   (i_period),
        .i_dat_xfer (i_dat_xfer),
        .i_null_req (i_null_req),
        .o_hdr_data (o_hdr_data),
        .o_hdr_null (o_hdr_null),
        .o_hdr_last (o_hdr_last),
        .o_hdr_valid(o_hdr_valid),
        .i_hdr_ready(i_hdr_ready),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one header item with ready high; bounded wait for valid.
    task automatic collect(input int max_wait);
        int w;
        cap_cnt  = 0;
        cap_null = 1'b0;
        cap_to   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cap_data[i] = 'x;
            cap_last[i] = 'x;
        end
        i_hdr_ready = 1'b1;
        w = 0;
        while (!o_hdr_valid && w < max_wait) begin
            step();
            w++;
        end
        if (!o_hdr_valid) begin
            cap_to = 1'b1;
            return;
        end
        if (o_hdr_null) begin
            cap_null = 1'b1;
            step();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (!o_hdr_valid) break;
            cap_data[i] = o_hdr_data;
            cap_last[i] = o_hdr_last;
            cap_cnt++;
            step();
            if (cap_last[i] === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_hdr_valid); end
        checks++; if (o_hdr_null !== 1'b0) begin errors++; $display("FAIL rst_null: got %b expected 0", o_hdr_null); end
        checks++; if (o_hdr_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", o_hdr_last); end
        checks++; if (o_hdr_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", o_hdr_data); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", o_overrun); end
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_periodic();
        i_period    = 16'd4;
        i_hdr_ready = 1'b1;
        i_dat_xfer  = 1'b1;
        repeat (4) step();
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL per_latency: valid got %b expected 0", o_hdr_valid); end
        step();  // 5th xfer lands on the IDLE->SEND edge
        exp_hdr = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_hdr_valid !== 1'b1 || o_hdr_data !== exp_hdr[i] || o_hdr_last !== (i == 4)) begin
                errors++;
                $display("FAIL per_hdr1[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, o_hdr_valid, o_hdr_data, o_hdr_last, exp_hdr[i], (i == 4));
            end
            i_dat_xfer = (i < 3);
            step();
        end
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL per_gap: valid got %b expected 0", o_hdr_valid); end
        collect(10);
        exp_hdr = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00};
        checks++;
        if (cap_to || cap_cnt != 5) begin errors++; $display("FAIL per_hdr2_len: got %0d timeout=%b expected 5", cap_cnt, cap_to); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_data[i] !== exp_hdr[i] || cap_last[i] !== (i == 4)) begin
                errors++;
                $display("FAIL per_hdr2[%0d]: got d=%h l=%b expected d=%h l=%b",
                         i, cap_data[i], cap_last[i], exp_hdr[i], (i == 4));
            end
        end
    endtask

    task automatic test_stall();
        i_dat_xfer = 1'b1;
        repeat (4) step();  // tot_cnt = 12
        i_dat_xfer = 1'b0;
        step();
        checks++; if (o_hdr_valid !== 1'b1 || o_hdr_data !== 8'h02) begin errors++; $display("FAIL stall_seq: got v=%b d=%h expected v=1 d=02", o_hdr_valid, o_hdr_data); end
        step();
        i_hdr_ready = 1'b0;
        i_dat_xfer  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_hdr_valid !== 1'b1 || o_hdr_data !== 8'h0c || o_hdr_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h l=%b expected v=1 d=0c l=0",
                         i, o_hdr_valid, o_hdr_data, o_hdr_last);
            end
        end
        i_hdr_ready = 1'b1;
        i_dat_xfer  = 1'b0;
        exp_hdr = '{8'h0c, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_hdr_valid !== 1'b1 || o_hdr_data !== exp_hdr[i] || o_hdr_last !== (i == 3)) begin
                errors++;
                $display("FAIL stall_tail[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, o_hdr_valid, o_hdr_data, o_hdr_last, exp_hdr[i], (i == 3));
            end
            step();
        end
        // 3 stalled xfers plus this one complete the next period at tot_cnt 16
        i_dat_xfer = 1'b1;
        step();
        i_dat_xfer = 1'b0;
        collect(10);
        exp_hdr = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
        checks++;
        if (cap_to || cap_cnt != 5) begin errors++; $display("FAIL stall_hdr_len: got %0d timeout=%b expected 5", cap_cnt, cap_to); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_data[i] !== exp_hdr[i]) begin
                errors++;
                $display("FAIL stall_hdr[%0d]: got %h expected %h", i, cap_data[i], exp_hdr[i]);
            end
        end
    endtask

    task automatic test_null();
        i_hdr_ready = 1'b0;
        i_null_req  = 1'b1;
        step();
        i_null_req = 1'b0;
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL null_lat: valid got %b expected 0", o_hdr_valid); end
        step();
        checks++;
        if (o_hdr_valid !== 1'b1 || o_hdr_null !== 1'b1 || o_hdr_last !== 1'b0 || o_hdr_data !== 8'h00) begin
            errors++;
            $display("FAIL null_item: got v=%b n=%b l=%b d=%h expected v=1 n=1 l=0 d=00",
                     o_hdr_valid, o_hdr_null, o_hdr_last, o_hdr_data);
        end
        i_null_req = 1'b1; step();
        i_null_req = 1'b0; step();
        i_null_req = 1'b1; step();
        i_null_req = 1'b0;
        checks++; if (o_hdr_valid !== 1'b1 || o_hdr_null !== 1'b1) begin errors++; $display("FAIL null_hold: got v=%b n=%b expected v=1 n=1", o_hdr_valid, o_hdr_null); end
        i_hdr_ready = 1'b1;
        step();
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL null_gap: valid got %b expected 0", o_hdr_valid); end
        step();
        checks++; if (o_hdr_valid !== 1'b1 || o_hdr_null !== 1'b1) begin errors++; $display("FAIL null_merged: got v=%b n=%b expected v=1 n=1", o_hdr_valid, o_hdr_null); end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL null_extra[%0d]: valid got %b expected 0", i, o_hdr_valid); end
            step();
        end
    endtask

    task automatic test_priority();
        i_dat_xfer = 1'b1;
        repeat (3) step();
        i_null_req = 1'b1;
        step();  // tot_cnt = 20, both requests pending
        i_dat_xfer = 1'b0;
        i_null_req = 1'b0;
        collect(10);
        exp_hdr = '{8'h04, 8'h14, 8'h00, 8'h00, 8'h00};
        checks++;
        if (cap_to || cap_null || cap_cnt != 5) begin
            errors++;
            $display("FAIL prio_first: got cnt=%0d null=%b timeout=%b expected cnt=5 null=0", cap_cnt, cap_null, cap_to);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_data[i] !== exp_hdr[i]) begin errors++; $display("FAIL prio_hdr[%0d]: got %h expected %h", i, cap_data[i], exp_hdr[i]); end
        end
        collect(10);
        checks++; if (cap_to || !cap_null) begin errors++; $display("FAIL prio_null: got null=%b timeout=%b expected null=1", cap_null, cap_to); end
    endtask

    task automatic test_overrun();
        i_period    = 16'd2;
        i_hdr_ready = 1'b0;
        i_dat_xfer  = 1'b1;
        repeat (6) step();  // tot_cnt = 26; header seq 5 stuck with snap 22
        i_dat_xfer = 1'b0;
        i_period   = 16'd0;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", o_overrun); end
        checks++; if (o_hdr_valid !== 1'b1 || o_hdr_data !== 8'h05) begin errors++; $display("FAIL ovr_stuck: got v=%b d=%h expected v=1 d=05", o_hdr_valid, o_hdr_data); end
        // The in-flight header drains first, then the single merged pending one.
        collect(10);
        checks++; if (cap_to || cap_cnt != 5 || cap_data[1] !== 8'h16) begin errors++; $display("FAIL ovr_hdr_a: got cnt=%0d snap0=%h expected cnt=5 snap0=16", cap_cnt, cap_data[1]); end
        collect(10);
        checks++; if (cap_to || cap_cnt != 5 || cap_data[0] !== 8'h06 || cap_data[1] !== 8'h1a) begin errors++; $display("FAIL ovr_hdr_b: got cnt=%0d seq=%h snap0=%h expected cnt=5 seq=06 snap0=1a", cap_cnt, cap_data[0], cap_data[1]); end
        for (int i = 0; i < 8; i++) begin
            i_dat_xfer = (i < 6);
            step();
            checks++;
            if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL ovr_period0[%0d]: valid got %b expected 0", i, o_hdr_valid); end
        end
        i_dat_xfer = 1'b0;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", o_overrun); end
    endtask

    task automatic test_mid_reset();
        i_period    = 16'd4;
        i_hdr_ready = 1'b1;
        i_dat_xfer  = 1'b1;
        repeat (4) step();  // tot_cnt = 36
        i_dat_xfer = 1'b0;
        step();
        checks++; if (o_hdr_data !== 8'h07) begin errors++; $display("FAIL mrst_seq: got %h expected 07", o_hdr_data); end
        step();
        checks++; if (o_hdr_data !== 8'h24) begin errors++; $display("FAIL mrst_snap: got %h expected 24", o_hdr_data); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (o_hdr_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", o_hdr_valid); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL mrst_overrun: got %b expected 0", o_overrun); end
        @(negedge clk);
        rst = 1'b0;
        i_dat_xfer = 1'b1;
        repeat (4) step();
        i_dat_xfer = 1'b0;
        collect(10);
        exp_hdr = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        checks++;
        if (cap_to || cap_cnt != 5) begin errors++; $display("FAIL mrst_len: got %0d timeout=%b expected 5", cap_cnt, cap_to); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_data[i] !== exp_hdr[i]) begin errors++; $display("FAIL mrst_hdr[%0d]: got %h expected %h", i, cap_data[i], exp_hdr[i]); end
        end
    endtask

    initial begin
        i_period    = 16'd0;
        i_dat_xfer  = 1'b0;
        i_null_req  = 1'b0;
        i_hdr_ready = 1'b0;
        test_reset();
        test_periodic();
        test_stall();
        test_null();
        test_priority();
        test_overrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
